serial_tx: RTL and testbench

Parallel-to-serial transmitter that drives the single-bit serial line consumed by the team's shift-register receive chains. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock with a per-bit strobe and a last-bit marker. It supports back-to-back words with no idle gap. It sits between a word-oriented producer and any downstream serial pipeline stage.

---
 rtl/serial_tx.sv | 83 ++++++++
 tb/tb_serial_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word over valid/ready and
// emits it one bit per clock with q_valid/q_last, streaming back-to-back words.
module serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             q,
  output logic             q_valid,
  output logic             q_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sr, sr_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             q_next, q_valid_next, q_last_next;
  logic             at_last, take;

  assign at_last   = (state == SHIFT) && (cnt == LAST);
  assign din_ready = rst_n && ((state == IDLE) || at_last);
  assign take      = din_valid && din_ready;
  assign busy      = (state == SHIFT);

  // sr always holds the untransmitted bits aligned so the next bit sits at
  // index 1 (LSB-first) or WIDTH-2 (MSB-first) relative to the bit on q.
  always_comb begin
    state_next   = state;
    sr_next      = sr;
    cnt_next     = cnt;
    q_next       = 1'b0;
    q_valid_next = 1'b0;
    q_last_next  = 1'b0;
    if (take) begin
      state_next   = SHIFT;
      sr_next      = din;
      cnt_next     = '0;
      q_next       = MSB_FIRST ? din[WIDTH-1] : din[0];
      q_valid_next = 1'b1;
      q_last_next  = (WIDTH == 1);
    end else if (state == SHIFT && !at_last) begin
      cnt_next     = cnt + CW'(1);
      sr_next      = MSB_FIRST ? (sr << 1) : (sr >> 1);
      q_next       = MSB_FIRST ? sr[WIDTH-2] : sr[1];
      q_valid_next = 1'b1;
      q_last_next  = ((cnt + CW'(1)) == LAST);
    end else if (at_last) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
    end else begin
      state   <= state_next;
      sr      <= sr_next;
      cnt     <= cnt_next;
      q       <= q_next;
      q_valid <= q_valid_next;
      q_last  <= q_last_next;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Table-driven bench for serial_tx: one LSB-first and one MSB-first instance
// share stimulus; every row lists the inputs and expected outputs of one cycle.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       rdy_l, q_l, qv_l, ql_l, busy_l;
  logic       rdy_m, q_m, qv_m, ql_m, busy_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .q(q_l), .q_valid(qv_l), .q_last(ql_l), .busy(busy_l)
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .q(q_m), .q_valid(qv_m), .q_last(ql_m), .busy(busy_m)
  );

  typedef struct {
    bit       rst_n;
    bit       dv;
    bit [7:0] din;
    bit       exp_ql;    // q of the LSB-first instance
    bit       exp_qm;    // q of the MSB-first instance
    bit       exp_valid;
    bit       exp_last;
    bit       exp_busy;
    bit       exp_ready;
  } vec_t;

  vec_t tbl[$];

  function automatic void push(bit r, bit dv, bit [7:0] d, bit el, bit em,
                               bit ev, bit elast, bit eb, bit er);
    vec_t v;
    v.rst_n = r; v.dv = dv; v.din = d;
    v.exp_ql = el; v.exp_qm = em; v.exp_valid = ev;
    v.exp_last = elast; v.exp_busy = eb; v.exp_ready = er;
    tbl.push_back(v);
  endfunction

  function automatic void push_idle(bit dv, bit [7:0] d);
    push(1'b1, dv, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  // Eight bit cycles of a frame. seq literals read left-to-right in emission
  // order; din_valid rises with hold_din from bit cycle hold_from onward.
  function automatic void push_frame(bit [7:0] seq_l, bit [7:0] seq_m,
                                     int hold_from, bit [7:0] hold_din);
    for (int k = 0; k < 8; k++) begin
      push(1'b1, (k >= hold_from), (k >= hold_from) ? hold_din : 8'h00,
           seq_l[7-k], seq_m[7-k], 1'b1, (k == 7), 1'b1, (k == 7));
    end
  endfunction

  task automatic check(input string name, input int row, input logic got,
                       input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d got %b want %b", name, row, got, want);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  initial begin
    logic [7:0] got_l, got_m;
    int         nbits;
    bit         done;

    // Reset row, 20 idle cycles
    push(1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) push_idle(1'b0, 8'h00);

    // Single word 8'h1E
    push_idle(1'b1, 8'h1E);
    push_frame(8'b01111000, 8'b00011110, 8, 8'h00);
    push_idle(1'b0, 8'h00);

    // Back-to-back 8'h1E then 8'hFF, din_valid held
    push_idle(1'b1, 8'h1E);
    push_frame(8'b01111000, 8'b00011110, 0, 8'hFF);
    push_frame(8'b11111111, 8'b11111111, 8, 8'h00);
    push_idle(1'b0, 8'h00);

    // 8'hAA offered at cnt=2, held until the last-bit cycle
    push_idle(1'b1, 8'h1E);
    push_frame(8'b01111000, 8'b00011110, 2, 8'hAA);
    push_frame(8'b01010101, 8'b10101010, 8, 8'h00);
    push_idle(1'b0, 8'h00);

    // Reset mid-frame, then 8'h81
    push_idle(1'b1, 8'h1E);
    push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 1, 0);
    push(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 1, 0);
    push(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 0, 1, 0);
    push(1'b0, 1'b1, 8'h55, 0, 0, 0, 0, 0, 0);
    push_idle(1'b0, 8'h00);
    push_idle(1'b1, 8'h81);
    push_frame(8'b10000001, 8'b10000001, 8, 8'h00);
    push_idle(1'b0, 8'h00);

    rst_n = 1'b0;
    din_valid = 1'b0;
    din = 8'h00;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n     = tbl[i].rst_n;
      din_valid = tbl[i].dv;
      din       = tbl[i].din;
      #1;
      check("q_lsb",     i, q_l,    tbl[i].exp_ql);
      check("q_msb",     i, q_m,    tbl[i].exp_qm);
      check("q_valid",   i, qv_l,   tbl[i].exp_valid);
      check("q_valid_m", i, qv_m,   tbl[i].exp_valid);
      check("q_last",    i, ql_l,   tbl[i].exp_last);
      check("q_last_m",  i, ql_m,   tbl[i].exp_last);
      check("busy",      i, busy_l, tbl[i].exp_busy);
      check("busy_m",    i, busy_m, tbl[i].exp_busy);
      check("din_ready", i, rdy_l,  tbl[i].exp_ready);
      check("din_ready_m", i, rdy_m, tbl[i].exp_ready);
      $display("row %0d rst_n=%b dv=%b din=%h q=%b/%b qv=%b ql=%b busy=%b rdy=%b",
               i, rst_n, din_valid, din, q_l, q_m, qv_l, ql_l, busy_l, rdy_l);
    end

    // Free-running capture of 8'hB4 with a bounded wait for q_last
    @(negedge clk);
    din_valid = 1'b1;
    din = 8'hB4;
    #1;
    check("ready_b4", 0, rdy_l, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    din = 8'h00;
    got_l = 8'h00;
    got_m = 8'h00;
    nbits = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (qv_l && nbits < 8) begin
        got_l[nbits] = q_l;
        got_m[nbits] = q_m;
        nbits++;
      end
      if (ql_l) done = 1'b1;
      else @(negedge clk);
    end
    check("last_seen", 0, done, 1'b1);
    check_word("nbits_b4", nbits, 8);
    check_word("word_lsb_b4", {24'h0, got_l}, 32'hB4);
    check_word("word_msb_b4", {24'h0, got_m}, 32'h2D);
    $display("capture din=b4 lsb=%h msb=%h bits=%0d", got_l, got_m, nbits);
    @(negedge clk);
    #1;
    check("idle_after_b4", 0, qv_l, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
